// File: rtl/conv_feature_serializer_if.sv
// Output stream of the feature serializer: one IEEE-754 word per beat,
// tagged with feature map, row and column, under valid/ready flow control.
interface conv_feature_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  o_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [1:0]            o_feature_idx;
    logic [2:0]            o_row;
    logic [2:0]            o_col;
    logic                  o_last;

    modport master (
        output o_valid,
        output o_data,
        output o_feature_idx,
        output o_row,
        output o_col,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid,
        input  o_data,
        input  o_feature_idx,
        input  o_row,
        input  o_col,
        input  o_last,
        output o_ready
    );
endinterface

// File: rtl/conv_feature_serializer.sv
// Captures completed feature rows from the kernel array, applies optional
// ReLU, buffers them in a two-entry ping-pong store and streams them out one
// word per beat. Lane 0 of the parallel bus sits in the MSBs.
module conv_feature_serializer #(
    parameter int ARRAY_SIZE = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 6,
    parameter int FEATURES   = 4,
    parameter int RELU_EN    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,   // synchronous, active-high
    input  logic                           kernel_calc_fin,
    input  logic [1:0]                     feature_idx,
    input  logic [2:0]                     feature_row,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature_in,
    conv_feature_serializer_if.master      out_if,
    output logic                           overflow,
    output logic [1:0]                     buf_count
);
    localparam int         ROW_W     = ARRAY_SIZE * DATA_WIDTH;
    localparam logic [2:0] LAST_COL  = 3'(ARRAY_SIZE - 1);
    localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);
    localparam logic [1:0] LAST_FEAT = 2'(FEATURES - 1);

    // Zero every lane whose sign bit is set (covers -0 and negative NaN).
    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] res;
        res = row;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (row[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
                res[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else begin
                res[i*DATA_WIDTH +: DATA_WIDTH] = row[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    logic             fin_prev_q, fin_prev_d;
    logic [ROW_W-1:0] data_q [2];
    logic [ROW_W-1:0] data_d [2];
    logic [1:0]       idx_q  [2];
    logic [1:0]       idx_d  [2];
    logic [2:0]       row_q  [2];
    logic [2:0]       row_d  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [2:0]       col_q, col_d;
    logic             overflow_q, overflow_d;

    logic             cap_s, valid_s, hs_s, last_beat_s, wr_en_s, drop_s;
    logic [ROW_W-1:0] capt_row_s;
    logic [ROW_W-1:0] head_s;
    logic [DATA_WIDTH-1:0] lane_s;

    // Edge detect, handshake and buffer-admission decisions.
    always_comb begin
        cap_s       = kernel_calc_fin & ~fin_prev_q;
        valid_s     = (count_q != 2'd0);
        hs_s        = valid_s & out_if.o_ready;
        last_beat_s = hs_s & (col_q == LAST_COL);
        // A full buffer still admits a row when its head is freed this cycle.
        wr_en_s     = cap_s & ((count_q != 2'd2) | last_beat_s);
        drop_s      = cap_s & ~wr_en_s;
        capt_row_s  = (RELU_EN != 0) ? relu_row(feature_in) : feature_in;
    end

    // Next-state computation for the store, pointers, column and flags.
    always_comb begin
        fin_prev_d = kernel_calc_fin;
        data_d     = data_q;
        idx_d      = idx_q;
        row_d      = row_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        col_d      = col_q;
        overflow_d = overflow_q | drop_s;

        if (wr_en_s) begin
            data_d[wr_ptr_q] = capt_row_s;
            idx_d[wr_ptr_q]  = feature_idx;
            row_d[wr_ptr_q]  = feature_row;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (hs_s) begin
            col_d = last_beat_s ? 3'd0 : (col_q + 3'd1);
        end else begin
            col_d = col_q;
        end

        if (last_beat_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, last_beat_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fin_prev_q <= 1'b0;
            data_q[0]  <= {ROW_W{1'b0}};
            data_q[1]  <= {ROW_W{1'b0}};
            idx_q[0]   <= 2'd0;
            idx_q[1]   <= 2'd0;
            row_q[0]   <= 3'd0;
            row_q[1]   <= 3'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            col_q      <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            fin_prev_q <= fin_prev_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            col_q      <= col_d;
            overflow_q <= overflow_d;
        end
    end

    // Select lane col of the head entry; driven purely from registers so it
    // holds steady while the consumer stalls.
    always_comb begin
        head_s = data_q[rd_ptr_q];
        lane_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            lane_s = (col_q == 3'(i)) ? head_s[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] : lane_s;
        end
    end

    // Drive the stream and status outputs.
    always_comb begin
        out_if.o_valid       = valid_s;
        out_if.o_data        = lane_s;
        out_if.o_feature_idx = idx_q[rd_ptr_q];
        out_if.o_row         = row_q[rd_ptr_q];
        out_if.o_col         = col_q;
        out_if.o_last        = valid_s & (idx_q[rd_ptr_q] == LAST_FEAT) &
                               (row_q[rd_ptr_q] == LAST_ROW) & (col_q == LAST_COL);
        overflow             = overflow_q;
        buf_count            = count_q;
    end
endmodule

// File: doc/conv_feature_serializer.md
# conv_feature_serializer

Downstream of the convolution layer top. It captures each completed feature row from the kernel array's parallel bus (ARRAY_SIZE IEEE-754 words), applies ReLU, and buffers the row in a two-entry ping-pong store. It streams the row out one word per beat on a valid/ready interface, tagged with feature map, row and column coordinates. This decouples the fixed-timing kernel array from a back-pressuring consumer (pooling stage or external writer).

## Interface
- ARRAY_SIZE, 6, words per feature row (parallel lanes from the kernel array)
- DATA_WIDTH, 32, bits per word (IEEE-754 single)
- ROWS, 6, feature rows per feature map
- FEATURES, 4, feature maps per frame
- RELU_EN, 1, 1 = apply ReLU on capture, 0 = pass through

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-high (asserted = 1; name kept from codebase)
- kernel_calc_fin  in  1  row-complete level from the conv controller
- feature_idx  in  2  feature map index of the row being presented
- feature_row  in  3  row index of the row being presented
- feature_in  in  ARRAY_SIZE*DATA_WIDTH  feature row; lane 0 in the MSBs
- o_valid  out  1  output word valid
- o_ready  in  1  consumer accepts the word when o_valid && o_ready
- o_data  out  DATA_WIDTH  output word
- o_feature_idx  out  2  map tag of o_data
- o_row  out  3  row tag of o_data
- o_col  out  3  column (lane) tag of o_data, 0..ARRAY_SIZE-1
- o_last  out  1  high on the last word of a frame (feature_idx=FEATURES-1, row=ROWS-1, col=ARRAY_SIZE-1)
- overflow  out  1  sticky; set when a row is dropped, cleared only by reset
- buf_count  out  2  occupied buffer entries, 0..2

## Operation
- Capture on the rising edge of kernel_calc_fin: sampled high now and low on the previous cycle. A level held for several cycles captures once.
- Each captured entry stores all ARRAY_SIZE lanes plus feature_idx and feature_row.
- ReLU (RELU_EN=1): per lane, if bit DATA_WIDTH-1 is 1, store all-zeros. This covers -0 and negative NaN. Otherwise store unchanged.
- Buffer: two entries with write pointer, read pointer and count. Write on capture when count<2. The read side drains the oldest entry.
- Serializer: column counter col, 0..ARRAY_SIZE-1.
  - o_data = lane col of the head entry.
  - On each handshake, col increments.
  - On the handshake at col=ARRAY_SIZE-1, col wraps to 0, the entry is freed and the read pointer advances.
- Simultaneous capture and final-word handshake with count=2: the free and the write happen in the same cycle. The capture is accepted, count stays 2, and overflow is not set.
- Capture with count=2 and no same-cycle free: the row is dropped and overflow is set. Buffer contents and output stream are unaffected.
- o_valid = (count!=0). While o_valid is high and o_ready is low, o_data and all tags hold stable.
- o_last is combinational from the head tags and col. It is informational only and has no effect on control.
- Input tags are not range-checked; they pass through verbatim.

## Timing
- Reset values: o_valid=0, o_data=0, o_feature_idx=0, o_row=0, o_col=0, o_last=0, overflow=0, buf_count=0. Pointers and col are 0, and the edge-detect history is 0.
- Reset mid-stream discards all buffered rows immediately; o_valid is low in the next cycle.
- Capture latency: edge detected at clock edge t → entry written at t, buf_count and o_valid updated after edge t. The first word is presented in cycle t+1 if the buffer was empty.
- Throughput: one word per cycle with o_ready held high. A row drains in ARRAY_SIZE cycles with no bubble between back-to-back entries.
- A second capture edge needs kernel_calc_fin low for at least one cycle in between.

## Test plan
- Single row: feature_in lanes = 1.0,2.0,…,6.0 (0x3F800000…0x40C00000), idx=2, row=3, one-cycle fin, o_ready=1 → o_valid from cycle t+1 for exactly 6 cycles. o_col steps 0..5, data matches in order, tags are 2/3, o_last=0.
- ReLU: lanes = -1.0 (0xBF800000), 0x80000000, 0x7FC00000, 0.5, 0xFFC00000, 0 with RELU_EN=1 → outputs 0, 0, 0x7FC00000, 0x3F000000, 0, 0. With RELU_EN=0 → outputs unchanged.
- Back-pressure: o_ready toggles 1,0,0,1,… → o_data and tags hold during low cycles, and all 6 words arrive exactly once in order.
- Overflow: o_ready=0, three separated fin pulses → buf_count=2 after the second pulse. On the third, overflow=1 and buf_count stays 2. After draining, only rows 1 and 2 appear.
- Boundary: count=2 and a fin edge coincident with the handshake at col=5 → capture accepted, overflow stays 0, and three rows emerge in order.
- Frame end: row tags idx=3, row=5 → o_last=1 only on col=5. Then assert rst_n mid-row → o_valid=0 and buf_count=0 the next cycle.
